// File: rtl/scan_chain_controller.sv
`timescale 1ns/1ps
// scan_chain_controller: shifts one selected design's inputs into the shared scan chain,
// latches them, captures the design outputs and shifts them back out.
module scan_chain_controller #(
    parameter int NUM_DESIGNS = 8,
    parameter int NUM_IOS     = 8,
    parameter int SEL_WIDTH   = 9,
    parameter int DIV_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SEL_WIDTH-1:0] active_select,
    input  logic [NUM_IOS-1:0]   inputs,
    input  logic                 continuous,
    input  logic                 start,
    input  logic [DIV_WIDTH-1:0] clk_div,
    output logic [NUM_IOS-1:0]   outputs,
    output logic                 ready,
    output logic                 out_valid,
    output logic                 sel_error,
    output logic                 scan_clk,
    output logic                 scan_data_out,
    output logic                 scan_select,
    output logic                 scan_latch_enable,
    input  logic                 scan_data_in
);

    localparam int D_W = (NUM_DESIGNS > 1) ? $clog2(NUM_DESIGNS) : 1;
    localparam int K_W = (NUM_IOS > 1) ? $clog2(NUM_IOS) : 1;
    localparam logic [D_W-1:0]       D_LAST   = D_W'(NUM_DESIGNS - 1);
    localparam logic [K_W-1:0]       K_LAST   = K_W'(NUM_IOS - 1);
    localparam logic [SEL_WIDTH-1:0] SEL_LAST = SEL_WIDTH'(NUM_DESIGNS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, LATCH, CAPTURE, READ} state_t;

    state_t               state, state_n;
    logic [D_W-1:0]       d_cnt, d_n, d_adv;
    logic [K_W-1:0]       k_cnt, k_n, k_adv;
    logic [DIV_WIDTH-1:0] phase, phase_n, div_r;
    logic [SEL_WIDTH-1:0] target_r, target_new;
    logic [NUM_IOS-1:0]   inputs_r, shadow, shadow_n, shadow_cap, outputs_n;
    logic                 err_new, launch, tick, last_bit, in_win, adv_win;
    logic                 sclk_n, sdo_n, sel_n, le_n, valid_n;

    assign ready = (state == IDLE);

    // NOTE: every signal gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_n    = state;
        d_n        = d_cnt;
        k_n        = k_cnt;
        phase_n    = phase;
        sclk_n     = scan_clk;
        sdo_n      = scan_data_out;
        sel_n      = scan_select;
        le_n       = scan_latch_enable;
        shadow_n   = shadow;
        outputs_n  = outputs;
        valid_n    = 1'b0;
        launch     = 1'b0;

        err_new    = int'(active_select) >= NUM_DESIGNS;
        target_new = SEL_LAST - active_select;
        tick       = (phase == div_r);
        last_bit   = (d_cnt == D_LAST) && (k_cnt == K_LAST);

        if (k_cnt == K_LAST) begin
            k_adv = '0;
            d_adv = d_cnt + D_W'(1);
        end else begin
            k_adv = k_cnt + K_W'(1);
            d_adv = d_cnt;
        end

        in_win  = !sel_error && (SEL_WIDTH'(d_cnt) == target_r);
        adv_win = !sel_error && (SEL_WIDTH'(d_adv) == target_r);

        shadow_cap = shadow;
        if (in_win) shadow_cap[K_LAST - k_cnt] = scan_data_in;

        if (state != IDLE) phase_n = tick ? '0 : phase + DIV_WIDTH'(1);

        case (state)
            IDLE: begin
                if (continuous || start) begin
                    launch   = 1'b1;
                    state_n  = LOAD;
                    d_n      = '0;
                    k_n      = '0;
                    phase_n  = '0;
                    sclk_n   = 1'b0;
                    shadow_n = '0;
                    // First bit is driven straight from the launch values.
                    sdo_n    = (!err_new && target_new == '0) ? inputs[NUM_IOS-1] : 1'b0;
                end
            end
            LOAD: begin
                if (tick) begin
                    if (!scan_clk) begin
                        sclk_n = 1'b1;
                    end else begin
                        sclk_n = 1'b0;
                        if (last_bit) begin
                            state_n = LATCH;
                            le_n    = 1'b1;
                            d_n     = '0;
                            k_n     = '0;
                            sdo_n   = 1'b0;
                        end else begin
                            d_n   = d_adv;
                            k_n   = k_adv;
                            sdo_n = adv_win ? inputs_r[K_LAST - k_adv] : 1'b0;
                        end
                    end
                end
            end
            LATCH: begin
                if (tick) begin
                    le_n    = 1'b0;
                    sel_n   = 1'b1;
                    state_n = CAPTURE;
                end
            end
            CAPTURE: begin
                if (tick) begin
                    if (!scan_clk) begin
                        sclk_n = 1'b1;
                    end else begin
                        sclk_n  = 1'b0;
                        sel_n   = 1'b0;
                        state_n = READ;
                    end
                end
            end
            READ: begin
                if (tick) begin
                    if (!scan_clk) begin
                        sclk_n = 1'b1;
                    end else begin
                        sclk_n   = 1'b0;
                        shadow_n = shadow_cap;
                        if (last_bit) begin
                            if (!sel_error) outputs_n = shadow_cap;
                            valid_n = 1'b1;
                            state_n = IDLE;
                            d_n     = '0;
                            k_n     = '0;
                        end else begin
                            d_n = d_adv;
                            k_n = k_adv;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples the
    // pre-edge values computed above.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            d_cnt             <= '0;
            k_cnt             <= '0;
            phase             <= '0;
            div_r             <= '0;
            target_r          <= '0;
            // NOTE: the data registers are reset too; they are few and a cleared shadow
            // keeps the abort behaviour deterministic.
            inputs_r          <= '0;
            shadow            <= '0;
            outputs           <= '0;
            out_valid         <= 1'b0;
            sel_error         <= 1'b0;
            scan_clk          <= 1'b0;
            scan_data_out     <= 1'b0;
            scan_select       <= 1'b0;
            scan_latch_enable <= 1'b0;
        end else begin
            state             <= state_n;
            d_cnt             <= d_n;
            k_cnt             <= k_n;
            phase             <= phase_n;
            shadow            <= shadow_n;
            outputs           <= outputs_n;
            out_valid         <= valid_n;
            scan_clk          <= sclk_n;
            scan_data_out     <= sdo_n;
            scan_select       <= sel_n;
            scan_latch_enable <= le_n;
            if (launch) begin
                inputs_r  <= inputs;
                div_r     <= clk_div;
                target_r  <= target_new;
                sel_error <= err_new;
            end
        end
    end

endmodule

// File: tb/tb_scan_chain_controller.sv
`timescale 1ns/1ps
// Self-checking bench for scan_chain_controller: a behavioural scan-chain model feeds the
// DUT and every refresh is compared against expectations derived from the chain rules.
module tb_scan_chain_controller;

    localparam int ND = 8;
    localparam int NI = 8;
    localparam int N  = ND * NI;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [8:0] active_select = '0;
    logic [7:0] inputs = '0;
    logic       continuous = 1'b0;
    logic       start = 1'b0;
    logic [7:0] clk_div = '0;
    logic [7:0] outputs;
    logic       ready, out_valid, sel_error;
    logic       scan_clk, scan_data_out, scan_select, scan_latch_enable;
    logic       scan_data_in = 1'b0;

    // Second, small-geometry instance
    logic [8:0] active_select2 = '0;
    logic [3:0] inputs2 = '0;
    logic       start2 = 1'b0;
    logic [3:0] outputs2;
    logic       ready2, out_valid2, sel_error2;
    logic       scan_clk2, scan_data_out2, scan_select2, scan_latch_enable2;
    logic       scan_data_in2 = 1'b1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    scan_chain_controller u_dut (
        .clk(clk), .reset(reset), .active_select(active_select), .inputs(inputs),
        .continuous(continuous), .start(start), .clk_div(clk_div), .outputs(outputs),
        .ready(ready), .out_valid(out_valid), .sel_error(sel_error), .scan_clk(scan_clk),
        .scan_data_out(scan_data_out), .scan_select(scan_select),
        .scan_latch_enable(scan_latch_enable), .scan_data_in(scan_data_in)
    );

    scan_chain_controller #(.NUM_DESIGNS(4), .NUM_IOS(4)) u_dut2 (
        .clk(clk), .reset(reset), .active_select(active_select2), .inputs(inputs2),
        .continuous(1'b0), .start(start2), .clk_div(8'd0), .outputs(outputs2),
        .ready(ready2), .out_valid(out_valid2), .sel_error(sel_error2), .scan_clk(scan_clk2),
        .scan_data_out(scan_data_out2), .scan_select(scan_select2),
        .scan_latch_enable(scan_latch_enable2), .scan_data_in(scan_data_in2)
    );

    // Chain model: designs' outputs, what was shifted in, and what gets shifted back
    logic [7:0]   design_out [ND];
    logic [7:0]   exp_prev = '0;
    logic         model_clr = 1'b0;
    int           ld_p = 0, rd_p = 0, rises = 0, le_cycles = 0, viol = 0;
    logic         captured = 1'b0;
    logic [N-1:0] load_bits = '0;
    logic         p_sdo = 1'b0, p_sel = 1'b0, p_le = 1'b0;

    always @(posedge scan_clk or posedge model_clr) begin
        if (model_clr) begin
            ld_p         <= 0;
            rd_p         <= 0;
            rises        <= 0;
            captured     <= 1'b0;
            load_bits    <= '0;
            scan_data_in <= 1'b0;
        end else begin
            rises <= rises + 1;
            if (scan_select) begin
                captured <= 1'b1;
                rd_p     <= 0;
            end else if (captured) begin
                if (rd_p < N) scan_data_in <= design_out[ND-1-rd_p/NI][NI-1-rd_p%NI];
                rd_p <= rd_p + 1;
            end else if (ld_p < N) begin
                load_bits[ld_p] <= scan_data_out;
                ld_p            <= ld_p + 1;
            end
        end
    end

    always @(negedge clk or posedge model_clr) begin
        if (model_clr) begin
            le_cycles <= 0;
            viol      <= 0;
            p_sdo     <= 1'b0;
            p_sel     <= 1'b0;
            p_le      <= 1'b0;
        end else begin
            if (scan_latch_enable) le_cycles <= le_cycles + 1;
            if ((scan_latch_enable && scan_select) ||
                (scan_clk && (scan_data_out !== p_sdo || scan_select !== p_sel ||
                              scan_latch_enable !== p_le)))
                viol <= viol + 1;
            p_sdo <= scan_data_out;
            p_sel <= scan_select;
            p_le  <= scan_latch_enable;
        end
    end

    int           r2 = 0;
    logic [15:0]  ld2 = '0;
    always @(posedge scan_clk2) begin
        if (r2 < 16) ld2[r2] <= scan_data_out2;
        r2 <= r2 + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic arm();
        model_clr = 1'b1;
        #1;
        model_clr = 1'b0;
    endtask

    // Expected shift-in stream: first bit shifted is index 0; the selected design sits
    // NUM_DESIGNS-1-select windows from the start and receives inputs MSB first.
    function automatic logic [N-1:0] ref_stream(input logic [8:0] sel, input logic [7:0] inp);
        logic [N-1:0] s = '0;
        if (int'(sel) < ND)
            for (int k = 0; k < NI; k++) s[(ND-1-int'(sel))*NI + k] = inp[NI-1-k];
        return s;
    endfunction

    // Waits for the launch edge (inputs already driven), then follows one refresh.
    // mode 1: perturb inputs and pulse start mid-refresh; mode 2: drop continuous.
    task automatic run(input string tag, input logic [8:0] sel, input logic [7:0] inp,
                       input int h, input int mode);
        int         c;
        int         lat;
        logic [7:0] exp_out;
        logic       exp_err;
        lat     = 4*h*N + 3*h;
        exp_err = int'(sel) >= ND;
        exp_out = exp_err ? exp_prev : design_out[sel[2:0]];
        @(posedge clk);
        #1;
        start = 1'b0;
        arm();
        check({tag, ":ready_low"}, 64'(ready), 64'(0));
        check({tag, ":valid_low"}, 64'(out_valid), 64'(0));
        check({tag, ":sel_err"}, 64'(sel_error), 64'(exp_err));
        c = 0;
        while (c <= lat + 50) begin
            @(posedge clk);
            c++;
            #1;
            if (mode == 1 && c == 40) begin inputs = ~inp; start = 1'b1; end
            if (mode == 1 && c == 41) start = 1'b0;
            if (mode == 2 && c == 40) continuous = 1'b0;
            if (out_valid) break;
        end
        check({tag, ":latency"}, 64'(c), 64'(lat));
        check({tag, ":outputs"}, 64'(outputs), 64'(exp_out));
        check({tag, ":ready_hi"}, 64'(ready), 64'(1));
        check({tag, ":rises"}, 64'(rises), 64'(2*N + 1));
        check({tag, ":load"}, 64'(load_bits), 64'(ref_stream(sel, inp)));
        check({tag, ":latch_len"}, 64'(le_cycles), 64'(h));
        check({tag, ":chain_rules"}, 64'(viol), 64'(0));
        exp_prev = exp_out;
    endtask

    initial begin
        int         c;
        int         h;
        int         r0;
        logic [8:0] sel;
        logic [7:0] inp;

        for (int i = 0; i < ND; i++) design_out[i] = 8'($urandom);
        design_out[3] = 8'h3C;

        repeat (2) @(negedge clk);
        check("reset:outs", 64'({outputs, out_valid, sel_error, scan_clk, scan_data_out,
                                 scan_select, scan_latch_enable}), 64'(0));
        check("reset:ready", 64'(ready), 64'(1));
        reset = 1'b1;
        arm();
        repeat (10) @(negedge clk);
        check("idle:no_clk", 64'(rises), 64'(0));

        // Directed: select 3, inputs 0xA5, H=1 then H=4
        active_select = 9'd3; inputs = 8'hA5; clk_div = 8'd0; start = 1'b1;
        run("d3_h1", 9'd3, 8'hA5, 1, 0);
        @(negedge clk);
        clk_div = 8'd3; start = 1'b1;
        run("d3_h4", 9'd3, 8'hA5, 4, 0);

        // Out-of-range select holds previous result, then a valid launch clears the error
        @(negedge clk);
        active_select = 9'd8; inputs = 8'hFF; clk_div = 8'd0; start = 1'b1;
        run("err8", 9'd8, 8'hFF, 1, 0);
        @(negedge clk);
        active_select = 9'd0; inputs = 8'h81; start = 1'b1;
        run("sel0", 9'd0, 8'h81, 1, 0);

        // Randomized refreshes, including out-of-range selects
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < ND; i++) design_out[i] = 8'($urandom);
            sel = 9'($urandom_range(0, 10));
            inp = 8'($urandom);
            h   = int'($urandom_range(1, 3));
            @(negedge clk);
            active_select = sel; inputs = inp; clk_div = 8'(h - 1); start = 1'b1;
            run($sformatf("rnd%0d", it), sel, inp, h, 0);
        end

        // Reset asserted in the middle of LOAD aborts at once
        @(negedge clk);
        active_select = 9'd3; inputs = 8'hA5; clk_div = 8'd0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("abort:outs", 64'({outputs, out_valid, sel_error, scan_clk, scan_data_out,
                                 scan_select, scan_latch_enable}), 64'(0));
        check("abort:ready", 64'(ready), 64'(1));
        @(negedge clk);
        reset = 1'b1;
        exp_prev = '0;
        arm();
        repeat (20) @(posedge clk);
        #1;
        check("abort:quiet", 64'(rises), 64'(0));

        // Continuous mode: mid-refresh changes wait for the next launch
        for (int i = 0; i < ND; i++) design_out[i] = 8'($urandom);
        @(negedge clk);
        active_select = 9'd5; inputs = 8'h5A; clk_div = 8'd0; continuous = 1'b1;
        run("cont1", 9'd5, 8'h5A, 1, 1);
        run("cont2", 9'd5, 8'hA5, 1, 0);
        run("cont3", 9'd5, 8'hA5, 1, 2);
        r0 = rises;
        repeat (30) @(posedge clk);
        #1;
        check("cont:stopped", 64'(rises), 64'(r0));
        check("cont:ready", 64'(ready), 64'(1));

        // Small geometry: 4 designs x 4 bits, select 0 -> data window d=3
        @(negedge clk);
        active_select2 = 9'd0; inputs2 = 4'b1011; start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        c = 0;
        while (c <= 200) begin
            @(posedge clk);
            c++;
            #1;
            if (out_valid2) break;
        end
        check("small:latency", 64'(c), 64'(67));
        check("small:outputs", 64'(outputs2), 64'(4'hF));
        check("small:load", 64'(ld2), 64'(16'hD000));
        check("small:rises", 64'(r2), 64'(33));
        check("small:sel_err", 64'(sel_error2), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
